// File: rtl/aes_pkg.sv
// Shared AES-128 types, round constants and byte-level transforms
// used by the round sequencer and its key-schedule step.
package aes_pkg;

   localparam int NR = 10;

   typedef logic [7:0]   byte_t;
   typedef logic [31:0]  word_t;
   typedef logic [127:0] block_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fsm_t;

   localparam byte_t RCON [1:10] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   function automatic byte_t rcon_of(logic [3:0] r);
      byte_t v;
      v = 8'h00;
      if (r >= 4'd1 && r <= 4'd10) v = RCON[r];
      return v;
   endfunction

   function automatic byte_t xtime(byte_t a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic byte_t gmul(byte_t a, byte_t b);
      byte_t p;
      byte_t x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // S-box as GF(2^8) inverse (a^254, 0 maps to 0) plus affine map
   function automatic byte_t sbox(byte_t a);
      byte_t r;
      byte_t sq;
      r  = 8'h01;
      sq = a;
      for (int i = 1; i < 8; i++) begin
         sq = gmul(sq, sq);
         r  = gmul(r, sq);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
           ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   function automatic word_t sub_word(word_t w);
      return {sbox(w[31:24]), sbox(w[23:16]),
              sbox(w[15:8]),  sbox(w[7:0])};
   endfunction

   function automatic block_t sub_bytes(block_t s);
      block_t o;
      o = '0;
      for (int i = 0; i < 16; i++)
         o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
      return o;
   endfunction

   function automatic block_t shift_rows(block_t s);
      block_t o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] =
               s[127-8*(4*((c+r)%4)+r) -: 8];
      return o;
   endfunction

   function automatic word_t mix_col(word_t w);
      byte_t a0, a1, a2, a3;
      {a0, a1, a2, a3} = w;
      return {
         xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
         a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
         a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
         xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
      };
   endfunction

   function automatic block_t mix_columns(block_t s);
      block_t o;
      o = '0;
      for (int c = 0; c < 4; c++)
         o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
      return o;
   endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-expansion step: current round key + Rcon
// to the next round key, fully combinational.
module aes_key_step
   import aes_pkg::*;
(
   input  logic [127:0] key_i,
   input  logic [7:0]   rcon_i,
   output logic [127:0] key_o
);

   word_t w0, w1, w2, w3;
   word_t n0, n1, n2, n3;

   assign {w0, w1, w2, w3} = key_i;

   assign n0 = w0 ^ sub_word({w3[23:0], w3[31:24]})
             ^ {rcon_i, 24'h0};
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;

   assign key_o = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryptor: one round per cycle on a single
// round datapath with the key schedule expanded on the fly.
module aes_round_sequencer #(
   parameter int NR     = aes_pkg::NR,
   parameter int DATA_W = 128
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_text,
   input  logic [DATA_W-1:0] in_key,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_text,
   output logic              busy,
   output logic [3:0]        round
);

   import aes_pkg::*;

   if (NR != 10 || DATA_W != 128) begin : g_bad_cfg
      $error("aes_round_sequencer supports AES-128 only");
   end

   fsm_t   fsm_q, fsm_d;
   block_t state_q, state_d;
   block_t rkey_q, rkey_d;
   logic [3:0] round_q, round_d;

   block_t rkey_nx;
   block_t sb_sr;
   block_t mc;
   logic   last;

   aes_key_step u_key (
      .key_i  (rkey_q),
      .rcon_i (rcon_of(round_q)),
      .key_o  (rkey_nx)
   );

   assign sb_sr = shift_rows(sub_bytes(state_q));
   assign mc    = mix_columns(sb_sr);
   assign last  = (round_q == 4'(NR));

   always_comb begin
      fsm_d    = fsm_q;
      state_d  = state_q;
      rkey_d   = rkey_q;
      round_d  = round_q;
      in_ready = 1'b0;
      case (fsm_q)
         IDLE: in_ready = rst_n;
         RUN: begin
            rkey_d  = rkey_nx;
            state_d = (last ? sb_sr : mc) ^ rkey_nx;
            if (last) begin
               round_d = 4'd0;
               fsm_d   = DONE;
            end else begin
               round_d = round_q + 4'd1;
            end
         end
         DONE: begin
            in_ready = out_ready & rst_n;
            if (out_ready) fsm_d = IDLE;
         end
         default: begin
            fsm_d   = IDLE;
            round_d = 4'd0;
         end
      endcase
      // Accept wins over the DONE->IDLE drain for back-to-back jobs
      if (in_valid && in_ready) begin
         state_d = in_text ^ in_key;
         rkey_d  = in_key;
         round_d = 4'd1;
         fsm_d   = RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fsm_q   <= IDLE;
         state_q <= '0;
         rkey_q  <= '0;
         round_q <= 4'd0;
      end else begin
         fsm_q   <= fsm_d;
         state_q <= state_d;
         rkey_q  <= rkey_d;
         round_q <= round_d;
      end
   end

   assign out_valid = (fsm_q == DONE);
   assign out_text  = state_q;
   assign busy      = (fsm_q == RUN);
   assign round     = round_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer using FIPS-197 vectors.
module tb_aes_round_sequencer;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_text;
   logic [127:0] in_key;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_text;
   logic         busy;
   logic [3:0]   round;

   int n_chk  = 0;
   int n_pass = 0;

   localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

   always #5 clk = ~clk;

   aes_round_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_text   (in_text),
      .in_key    (in_key),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_text  (out_text),
      .busy      (busy),
      .round     (round)
   );

   task automatic chk(input string tag,
                      input logic [127:0] got,
                      input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!out_valid && n < 40) begin
         step();
         n++;
      end
   endtask

   task automatic accept(input logic [127:0] k,
                         input logic [127:0] p);
      in_key   = k;
      in_text  = p;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk({tag, "_drained"}, out_valid, 0);
   endtask

   int n;
   int n2;
   int bad;
   logic [127:0] held;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_text   = '0;
      in_key    = '0;
      step();
      step();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_round", round, 0);
      chk("rst_out_text", out_text, 0);
      rst_n = 1'b1;
      #1;
      chk("idle_in_ready", in_ready, 1);

      // C.1 vector and latency
      accept(K1, P1);
      chk("c1_busy", busy, 1);
      wait_valid(n);
      chk("c1_latency", n, 10);
      chk("c1_text", out_text, C1);
      chk("c1_busy_done", busy, 0);
      drain("c1");
      chk("c1_idle_ready", in_ready, 1);

      // App.B vector with round trace and backpressure
      accept(K2, P2);
      chk("b_round1", round, 1);
      for (int k = 2; k <= 10; k++) begin
         step();
         chk($sformatf("b_round%0d", k), round, k);
      end
      step();
      chk("b_valid", out_valid, 1);
      chk("b_round_end", round, 0);
      chk("b_text", out_text, C2);
      held = out_text;
      bad  = 0;
      in_key   = K1;
      in_text  = P1;
      in_valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         step();
         if (!out_valid || out_text !== held || in_ready) bad++;
      end
      in_valid = 1'b0;
      chk("bp_stable", bad, 0);
      drain("bp");
      bad = 0;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         if (out_valid) bad++;
      end
      out_ready = 1'b0;
      chk("bp_one_xfer", bad, 0);

      // Back-to-back jobs with in_valid held
      out_ready = 1'b1;
      accept(K1, P1);
      in_valid = 1'b1;
      in_key   = K2;
      in_text  = P2;
      wait_valid(n);
      chk("bb1_latency", n, 10);
      chk("bb1_text", out_text, C1);
      step();
      chk("bb_accept_vld", out_valid, 0);
      chk("bb_accept_busy", busy, 1);
      in_valid = 1'b0;
      wait_valid(n2);
      chk("bb_spacing", n2 + 1, 11);
      chk("bb2_text", out_text, C2);
      step();
      out_ready = 1'b0;
      chk("bb_end", out_valid, 0);

      // Reset at round 5
      accept(K2, P2);
      for (int k = 0; k < 4; k++) step();
      chk("rr_round5", round, 5);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("rr_busy", busy, 0);
      chk("rr_round", round, 0);
      bad = 0;
      for (int k = 0; k < 15; k++) begin
         step();
         if (out_valid) bad++;
      end
      chk("rr_no_stray", bad, 0);
      accept(K2, P2);
      wait_valid(n);
      chk("rr_latency", n, 10);
      chk("rr_text", out_text, C2);
      drain("rr");

      // Input churn while running
      accept(K1, P1);
      n = 0;
      while (!out_valid && n < 40) begin
         in_valid = 1'b1;
         in_text  = {$urandom, $urandom, $urandom, $urandom};
         in_key   = {$urandom, $urandom, $urandom, $urandom};
         step();
         n++;
      end
      in_valid = 1'b0;
      chk("ch_latency", n, 10);
      chk("ch_text", out_text, C1);
      drain("ch");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
